// File: rtl/risc_alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, flag bit positions,
// handshake FSM encoding and the common N/Z/C/V packing helper.
package risc_alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOT = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;
  localparam logic [3:0] ALU_SRA = 4'h8;
  localparam logic [3:0] ALU_MUL = 4'h9;
  localparam logic [3:0] ALU_DIV = 4'hA;
  localparam logic [3:0] ALU_REM = 4'hB;

  // alu_flags = {N,Z,C,V}
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // EXEC is the operand-latched cycle in which single-cycle ops resolve
  // and iterative ops launch the engine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  function automatic logic [3:0] mk_flags(input logic [ALU_W-1:0] res,
                                          input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = res[ALU_W-1];
    f[FLG_Z] = (res == '0);
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Start/busy/done handshake and result bus between the decode stage and the ALU.
interface alu_exec_if #(parameter int WIDTH = 16);
  logic             alu_start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_busy;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             alu_div0;

  modport master (output alu_start, alu_op, alu_a, alu_b,
                  input  alu_busy, alu_done, alu_result, alu_flags, alu_div0);
  modport slave  (input  alu_start, alu_op, alu_a, alu_b,
                  output alu_busy, alu_done, alu_result, alu_flags, alu_div0);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned MUL / DIV / REM engine: loads on start_i, then runs
// exactly WIDTH steps. done_o is raised in the last step and result_o/carry_o
// present that step's next-state value so the parent can register it directly.
module alu_muldiv_iter
  import risc_alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  // acc: product high half (MUL) or partial remainder (DIV/REM)
  // lo:  multiplier bits shifting out (MUL) or dividend in / quotient out (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   msum, rsh, rdiff;
  logic             is_mul;

  // One shift-add or restoring-division step
  always_comb begin
    is_mul = (op_i == ALU_MUL);
    msum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    rsh    = {acc_q, lo_q[WIDTH-1]};
    rdiff  = rsh - {1'b0, dvs_q};
    acc_d  = acc_q;
    lo_d   = lo_q;
    if (is_mul) begin
      acc_d = msum[WIDTH:1];
      lo_d  = {msum[0], lo_q[WIDTH-1:1]};
    end else if (!rdiff[WIDTH]) begin
      acc_d = rdiff[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rsh[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], 1'b0};
    end
    done_o   = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    result_o = (op_i == ALU_REM) ? acc_d : lo_d;
    carry_o  = is_mul && (acc_d != '0);
  end

  // Operand load and step sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= a_i;
      dvs_q <= b_i;
    end else if (run_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus optional
// iterative unsigned MUL/DIV/REM, behind a start/busy/done handshake.
// Result, flags and div0 are registered and held until the next done pulse.
// Build option: define ALU_MULDIV_EN to include the iterative engine; without
// it, opcodes 9-B behave as reserved single-cycle ops.
module alu_exec_unit
  import risc_alu_pkg::*;
#(
  parameter int WIDTH   = ALU_W,
  parameter int SHAMT_W = 4
) (
  input  logic     clk,
  input  logic     reset,
  alu_exec_if.slave bus
);
  alu_state_e       state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             busy_q, done_q, div0_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0]        sc_res;
  logic                    sc_c, sc_v, sc_div0, launch_iter;
  logic [SHAMT_W-1:0]      sh;
  logic [WIDTH:0]          sum, diff, shl_w, shr_w;
  logic signed [WIDTH:0]   sra_w;
  logic                    md_done, md_carry;
  logic [WIDTH-1:0]        md_res;

  // Single-cycle result from the latched operands; the extra bit on each
  // shifter catches the last bit shifted out (zero when the amount is 0).
  always_comb begin
    sc_res      = '0;
    sc_c        = 1'b0;
    sc_v        = 1'b0;
    sc_div0     = 1'b0;
    launch_iter = 1'b0;
    sh          = b_q[SHAMT_W-1:0];
    sum         = {1'b0, a_q} + {1'b0, b_q};
    diff        = {1'b0, a_q} - {1'b0, b_q};
    shl_w       = {1'b0, a_q} << sh;
    shr_w       = {a_q, 1'b0} >> sh;
    sra_w       = $signed({a_q, 1'b0}) >>> sh;
    case (op_q)
      ALU_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_AND: sc_res = a_q & b_q;
      ALU_OR:  sc_res = a_q | b_q;
      ALU_XOR: sc_res = a_q ^ b_q;
      ALU_NOT: sc_res = ~a_q;
      ALU_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      ALU_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      ALU_SRA: begin
        sc_res = sra_w[WIDTH:1];
        sc_c   = sra_w[0];
      end
`ifdef ALU_MULDIV_EN
      ALU_MUL: launch_iter = 1'b1;
      ALU_DIV: begin
        if (b_q == '0) begin
          sc_res  = '1;
          sc_div0 = 1'b1;
        end else begin
          launch_iter = 1'b1;
        end
      end
      ALU_REM: begin
        if (b_q == '0) begin
          sc_res  = a_q;
          sc_div0 = 1'b1;
        end else begin
          launch_iter = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  ((state_q == ST_EXEC) && launch_iter),
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .done_o   (md_done),
    .result_o (md_res),
    .carry_o  (md_carry)
  );
`else
  assign md_done  = 1'b0;
  assign md_res   = '0;
  assign md_carry = 1'b0;
`endif

  // Handshake FSM; starts are only sampled in IDLE, so DONE-cycle starts drop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.alu_start) begin
            op_q    <= bus.alu_op;
            a_q     <= bus.alu_a;
            b_q     <= bus.alu_b;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (launch_iter) begin
            state_q <= ST_ITER;
          end else begin
            result_q <= sc_res;
            flags_q  <= mk_flags(sc_res, sc_c, sc_v);
            div0_q   <= sc_div0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_ITER: begin
          if (md_done) begin
            result_q <= md_res;
            flags_q  <= mk_flags(md_res, md_carry, 1'b0);
            div0_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_busy   = busy_q;
  assign bus.alu_done   = done_q;
  assign bus.alu_result = result_q;
  assign bus.alu_flags  = flags_q;
  assign bus.alu_div0   = div0_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations are queued when an op is
// driven and popped when alu_done fires. Follows ALU_MULDIV_EN like the DUT.
module tb_alu_exec_unit;
  import risc_alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(16)) bus ();
  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        d0;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

`ifdef ALU_MULDIV_EN
  localparam int MD_LAT = 18;
  localparam int RST_AT = 6;
`else
  localparam int MD_LAT = 2;
  localparam int RST_AT = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference using plain arithmetic operators
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] w;
    logic [31:0] p;
    logic c, v;
    int sh;
    sh = int'(b[3:0]);
    c = 1'b0; v = 1'b0;
    e.d0 = 1'b0; e.lat = 2; e.res = '0; e.tag = "";
    case (op)
      4'h0: begin w = a + b; e.res = w[15:0]; c = w[16];
                  v = (a[15] == b[15]) && (e.res[15] != a[15]); end
      4'h1: begin e.res = a - b; c = (a < b);
                  v = (a[15] != b[15]) && (e.res[15] != a[15]); end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = ~a;
      4'h6: begin e.res = a << sh; c = (sh == 0) ? 1'b0 : a[16-sh]; end
      4'h7: begin e.res = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
      4'h8: begin e.res = $signed(a) >>> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
`ifdef ALU_MULDIV_EN
      4'h9: begin p = a * b; e.res = p[15:0]; c = (p[31:16] != 0); e.lat = 18; end
      4'hA: if (b == 0) begin e.res = 16'hFFFF; e.d0 = 1'b1; end
            else begin e.res = a / b; e.lat = 18; end
      4'hB: if (b == 0) begin e.res = a; e.d0 = 1'b1; end
            else begin e.res = a % b; e.lat = 18; end
`endif
      default: e.res = '0;
    endcase
    e.flg = {e.res[15], e.res == 16'h0, c, v};
    return e;
  endfunction

  // Launch one op, scramble inputs after acceptance, check result on done
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit dir, input logic [15:0] er,
                       input logic [3:0] ef, input logic ed0, input int elat);
    exp_t e;
    int n;
    if (dir) begin
      e.res = er; e.flg = ef; e.d0 = ed0; e.lat = elat;
    end else begin
      e = model(op, a, b);
    end
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    bus.alu_start = 1'b1; bus.alu_op = op; bus.alu_a = a; bus.alu_b = b;
    @(negedge clk);
    n = 1;
    bus.alu_start = 1'b0; bus.alu_op = ~op; bus.alu_a = ~a; bus.alu_b = a ^ b;
    chk({tag, "/busy"}, bus.alu_busy, 1);
    while (!bus.alu_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (!bus.alu_done) begin
      chk({tag, "/timeout"}, 0, 1);
    end else begin
      chk({tag, "/lat"}, n, e.lat);
      chk({tag, "/res"}, bus.alu_result, e.res);
      chk({tag, "/flg"}, bus.alu_flags, e.flg);
      chk({tag, "/div0"}, bus.alu_div0, e.d0);
      chk({tag, "/busy_done"}, bus.alu_busy, 1);
      @(negedge clk);
      chk({tag, "/pulse"}, bus.alu_done, 0);
      chk({tag, "/idle"}, bus.alu_busy, 0);
      chk({tag, "/hold"}, bus.alu_result, e.res);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n, first, second, dones;
    bus.alu_start = 1'b0; bus.alu_op = '0; bus.alu_a = '0; bus.alu_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/busy", bus.alu_busy, 0);
    chk("rst/done", bus.alu_done, 0);
    chk("rst/res", bus.alu_result, 0);
    chk("rst/flg", bus.alu_flags, 0);
    chk("rst/div0", bus.alu_div0, 0);
    reset = 1'b0;

    do_op("add_ovf",  ALU_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 4'b1001, 0, 2);
    do_op("add_wrap", ALU_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 4'b0110, 0, 2);
    do_op("sub_brw",  ALU_SUB, 16'h0003, 16'h0005, 1, 16'hFFFE, 4'b1010, 0, 2);
    do_op("sra1",     ALU_SRA, 16'h8001, 16'h0001, 1, 16'hC000, 4'b1010, 0, 2);
    do_op("shl0",     ALU_SHL, 16'h8001, 16'h0010, 1, 16'h8001, 4'b1000, 0, 2);
    do_op("shl15",    ALU_SHL, 16'h0003, 16'h000F, 1, 16'h8000, 4'b1010, 0, 2);
    do_op("shr1",     ALU_SHR, 16'h0001, 16'h0001, 1, 16'h0000, 4'b0110, 0, 2);
    do_op("not",      ALU_NOT, 16'h00FF, 16'h1234, 1, 16'hFF00, 4'b1000, 0, 2);
    do_op("xor_z",    ALU_XOR, 16'hA5A5, 16'hA5A5, 1, 16'h0000, 4'b0100, 0, 2);
    do_op("rsvd_c",   4'hC,    16'h1234, 16'h5678, 1, 16'h0000, 4'b0100, 0, 2);
`ifdef ALU_MULDIV_EN
    do_op("mul34",    ALU_MUL, 16'd3,    16'd4,    1, 16'd12,   4'b0000, 0, 18);
    do_op("mul_hi",   ALU_MUL, 16'h0100, 16'h0100, 1, 16'h0000, 4'b0110, 0, 18);
    do_op("div",      ALU_DIV, 16'd100,  16'd7,    1, 16'd14,   4'b0000, 0, 18);
    do_op("rem",      ALU_REM, 16'd100,  16'd7,    1, 16'd2,    4'b0000, 0, 18);
    do_op("div0",     ALU_DIV, 16'd100,  16'd0,    1, 16'hFFFF, 4'b1000, 1, 2);
    do_op("rem0",     ALU_REM, 16'h1234, 16'd0,    1, 16'h1234, 4'b0000, 1, 2);
`else
    do_op("mul34",    ALU_MUL, 16'd3,    16'd4,    1, 16'h0000, 4'b0100, 0, 2);
    do_op("div",      ALU_DIV, 16'd100,  16'd7,    1, 16'h0000, 4'b0100, 0, 2);
    do_op("div0",     ALU_DIV, 16'd100,  16'd0,    1, 16'h0000, 4'b0100, 0, 2);
`endif

    // Start held high through a MUL: exactly one done, next op only after it
    e = model(ALU_MUL, 16'h0100, 16'h0100); e.tag = "hold_mul";
    sb.push_back(e);
    @(negedge clk);
    bus.alu_start = 1'b1; bus.alu_op = ALU_MUL; bus.alu_a = 16'h0100; bus.alu_b = 16'h0100;
    n = 0; first = -1; second = -1; dones = 0;
    while (n < 45 && !(second > 0 && n >= second + 3)) begin
      @(negedge clk);
      n++;
      if (bus.alu_done) begin
        dones++;
        e = sb.pop_front();
        chk({e.tag, "/res"}, bus.alu_result, e.res);
        chk({e.tag, "/flg"}, bus.alu_flags, e.flg);
        if (first < 0) begin
          first = n;
          bus.alu_op = ALU_ADD; bus.alu_a = 16'h1234; bus.alu_b = 16'h1111;
          e.res = 16'h2345; e.flg = 4'b0000; e.d0 = 1'b0; e.lat = 0; e.tag = "hold_add";
          sb.push_back(e);
        end else begin
          second = n;
        end
      end else if (first < 0) begin
        bus.alu_op = ALU_ADD; bus.alu_a = 16'($urandom); bus.alu_b = 16'($urandom);
      end
      if (first > 0 && n == first + 2) bus.alu_start = 1'b0;
    end
    bus.alu_start = 1'b0;
    chk("hold/first", first, MD_LAT);
    chk("hold/second", second, MD_LAT + 3);
    chk("hold/dones", dones, 2);
    sb.delete();

    // Reset mid-operation aborts without a done pulse and clears outputs
    do_op("pre_rst", ALU_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 4'b1001, 0, 2);
    @(negedge clk);
    bus.alu_start = 1'b1; bus.alu_op = ALU_MUL; bus.alu_a = 16'd3; bus.alu_b = 16'd5;
    @(negedge clk);
    bus.alu_start = 1'b0;
    repeat (RST_AT - 1) @(negedge clk);
    chk("abort/busy_pre", bus.alu_busy, 1);
    chk("abort/done_pre", bus.alu_done, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort/busy", bus.alu_busy, 0);
    chk("abort/res", bus.alu_result, 0);
    chk("abort/flg", bus.alu_flags, 0);
    chk("abort/div0", bus.alu_div0, 0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.alu_done) dones++;
    end
    chk("abort/nodone", dones, 0);

    // Random ops against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [3:0] op;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      do_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, 0, '0, '0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
